// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA draw blocks.
package vga_draw_pkg;

  localparam int unsigned CoordW = 11;

  typedef logic [CoordW-1:0] coord_t;
  typedef logic [7:0]        rgb332_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StFlash = 1'b1
  } flash_state_e;

  localparam rgb332_t BLACK = 8'h00;
  localparam rgb332_t WHITE = 8'hFF;
  localparam rgb332_t RED   = 8'hE0;

  // Inclusive unsigned range test; the +1 keeps a lower bound of 0 from folding to a constant.
  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (({1'b0, v} + 12'd1) > {1'b0, lo}) && (v <= hi);
  endfunction

endpackage

// File: rtl/flash_sequencer.sv
// Border flash sequencer: counts video frames and flips the colour phase every FLASH_PERIOD
// frames for FLASH_TOGGLES phases.
module flash_sequencer
  import vga_draw_pkg::*;
#(
  parameter int unsigned FLASH_PERIOD  = 8,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic flashReq,
  output logic phase,
  output logic busy
);

  localparam int unsigned FrameW  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int unsigned ToggleW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
  localparam logic [FrameW-1:0]  FrameLast  = FrameW'(FLASH_PERIOD - 1);
  localparam logic [ToggleW-1:0] ToggleLast = ToggleW'(FLASH_TOGGLES - 1);

  flash_state_e        state_q, state_d;
  logic [FrameW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ToggleW-1:0]  toggle_cnt_q, toggle_cnt_d;
  logic                phase_q, phase_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      phase_q      <= phase_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    phase_d      = phase_q;
    // A request always (re)starts the sequence and swallows a coincident frame pulse.
    if (flashReq) begin
      state_d      = StFlash;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
      phase_d      = 1'b0;
    end else if (state_q == StFlash && startOfFrame) begin
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
        if (toggle_cnt_q == ToggleLast) begin
          state_d      = StIdle;
          toggle_cnt_d = '0;
          phase_d      = 1'b0;
        end else begin
          toggle_cnt_d = toggle_cnt_q + 1'b1;
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  assign phase = phase_q;
  assign busy  = (state_q == StFlash);

endmodule

// File: rtl/frame_borders_draw.sv
// Playfield border renderer: frame plus optional divider, with a timed two-colour flash.
// Registered RGB332 output and draw request, one clock behind the pixel coordinates.
module frame_borders_draw
  import vga_draw_pkg::*;
#(
  parameter int unsigned X_LEFT        = 0,
  parameter int unsigned X_RIGHT       = 639,
  parameter int unsigned Y_TOP         = 0,
  parameter int unsigned Y_BOTTOM      = 479,
  parameter int unsigned THICKNESS     = 4,
  parameter bit          DIV_EN        = 1'b1,
  parameter int unsigned DIV_X         = 513,
  parameter int unsigned DIV_W         = 4,
  parameter rgb332_t     COLOR_ON      = WHITE,
  parameter rgb332_t     COLOR_ALT     = RED,
  parameter int unsigned FLASH_PERIOD  = 8,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [10:0]   pixelX,
  input  logic [10:0]   pixelY,
  input  logic          startOfFrame,
  input  logic          flashReq,
  output logic [7:0]    BG_RGB,
  output logic          bordersDrawReq,
  output logic          flashBusy
);

  localparam coord_t XL    = coord_t'(X_LEFT);
  localparam coord_t XR    = coord_t'(X_RIGHT);
  localparam coord_t YT    = coord_t'(Y_TOP);
  localparam coord_t YB    = coord_t'(Y_BOTTOM);
  localparam coord_t XLIn  = coord_t'(X_LEFT + THICKNESS - 1);
  localparam coord_t XRIn  = coord_t'(X_RIGHT - THICKNESS + 1);
  localparam coord_t YTIn  = coord_t'(Y_TOP + THICKNESS - 1);
  localparam coord_t YBIn  = coord_t'(Y_BOTTOM - THICKNESS + 1);
  localparam coord_t DxLo  = coord_t'(DIV_X);
  localparam coord_t DxHi  = coord_t'(DIV_X + DIV_W - 1);

  logic    phase, busy;
  logic    in_rect, in_band, frame_hit, div_hit, hit;
  rgb332_t sel_color;
  rgb332_t rgb_q, rgb_d;
  logic    req_q, req_d;

  flash_sequencer #(
    .FLASH_PERIOD (FLASH_PERIOD),
    .FLASH_TOGGLES(FLASH_TOGGLES)
  ) u_flash_sequencer (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .flashReq    (flashReq),
    .phase       (phase),
    .busy        (busy)
  );

  always_comb begin
    in_rect   = in_range(pixelX, XL, XR) && in_range(pixelY, YT, YB);
    in_band   = in_range(pixelX, XL, XLIn) || in_range(pixelX, XRIn, XR) ||
                in_range(pixelY, YT, YTIn) || in_range(pixelY, YBIn, YB);
    frame_hit = in_rect && in_band;
    div_hit   = DIV_EN && in_range(pixelX, DxLo, DxHi) && in_range(pixelY, YT, YB);
    hit       = frame_hit || div_hit;
    sel_color = (busy && !phase) ? COLOR_ALT : COLOR_ON;
    rgb_d     = hit ? sel_color : BLACK;
    req_d     = hit;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= BLACK;
      req_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      req_q <= req_d;
    end
  end

  assign BG_RGB         = rgb_q;
  assign bordersDrawReq = req_q;
  assign flashBusy      = busy;

endmodule
